traffic_phase_scheduler: RTL and testbench

TRAFFIC_PHASE_SCHEDULER -- requirements
Module: traffic_phase_scheduler

---
 rtl/traffic_pkg.sv | 52 +++++
 rtl/traffic_phase_scheduler_timer.sv | 31 +++
 rtl/traffic_phase_scheduler.sv | 159 +++++++++++++++
 tb/tb_traffic_phase_scheduler.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared types for the traffic phase scheduler: lamp codes, phase codes and
// helpers that map a crossing direction (0 = NS, 1 = EW) onto its phases.
package traffic_pkg;

   localparam logic [1:0] LIGHT_RED    = 2'b00;
   localparam logic [1:0] LIGHT_GREEN  = 2'b01;
   localparam logic [1:0] LIGHT_YELLOW = 2'b10;

   localparam logic DIR_NS = 1'b0;
   localparam logic DIR_EW = 1'b1;

   typedef enum logic [1:0] {
      RED    = LIGHT_RED,
      GREEN  = LIGHT_GREEN,
      YELLOW = LIGHT_YELLOW
   } light_e;

   typedef enum logic [2:0] {
      AR_NS     = 3'd0,
      NS_GREEN  = 3'd1,
      NS_YELLOW = 3'd2,
      AR_EW     = 3'd3,
      EW_GREEN  = 3'd4,
      EW_YELLOW = 3'd5,
      EMERG     = 3'd6
   } phase_e;

   function automatic phase_e allRedOf(logic dir);
      return dir ? AR_EW : AR_NS;
   endfunction

   function automatic phase_e greenOf(logic dir);
      return dir ? EW_GREEN : NS_GREEN;
   endfunction

   function automatic phase_e yellowOf(logic dir);
      return dir ? EW_YELLOW : NS_YELLOW;
   endfunction

   function automatic logic dirOf(phase_e ph);
      return (ph == AR_EW) || (ph == EW_GREEN) || (ph == EW_YELLOW);
   endfunction

   // EMERG shows green only toward the direction latched on entry.
   function automatic light_e lampFor(phase_e ph, logic emergDir, logic dir);
      if (ph == greenOf(dir)) return GREEN;
      if (ph == yellowOf(dir)) return YELLOW;
      if ((ph == EMERG) && (emergDir == dir)) return GREEN;
      return RED;
   endfunction

endpackage

// File: rtl/traffic_phase_scheduler_timer.sv
// Loadable down-counter: reloads on phase entry, steps down on tick and
// saturates at zero so a phase can be held indefinitely without ticks.
module phase_timer #(
   parameter int              CNT_W       = 8,
   parameter logic [CNT_W-1:0] RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             reset_i,
   input  logic             load_i,
   input  logic [CNT_W-1:0] loadValue_i,
   input  logic             tick_i,
   output logic [CNT_W-1:0] count_o,
   output logic             zero_o
);

   logic [CNT_W-1:0] count_q;

   always_ff @(posedge clk) begin
      if (reset_i) begin
         count_q <= RESET_VALUE;
      end else if (load_i) begin
         count_q <= loadValue_i;
      end else if (tick_i && (count_q != '0)) begin
         count_q <= count_q - 1'b1;
      end
   end

   assign count_o = count_q;
   assign zero_o  = (count_q == '0);

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Two-way intersection phase sequencer with pedestrian walk service and
// emergency preemption; all outputs come straight from registers.
module traffic_phase_scheduler
   import traffic_pkg::*;
#(
   parameter int GREEN_TICKS  = 10,
   parameter int YELLOW_TICKS = 3,
   parameter int ALLRED_TICKS = 2,
   parameter int WALK_TICKS   = 6,
   parameter int CNT_W        = 8
) (
   input  logic       clk,
   input  logic       rstb,
   input  logic       tick,
   input  logic       ped_req_ns,
   input  logic       ped_req_ew,
   input  logic       emerg_req,
   input  logic       emerg_dir,
   output logic [1:0] ns_light,
   output logic [1:0] ew_light,
   output logic       walk_ns,
   output logic       walk_ew,
   output logic [2:0] phase,
   output logic       phase_start
);

   // Walk ends on the tick that takes the green counter past this value.
   localparam logic [CNT_W-1:0] WALK_END = CNT_W'(GREEN_TICKS - WALK_TICKS);
   localparam logic             WALK_EN  = (WALK_TICKS > 0);

   phase_e           phase_q, phase_d;
   logic             emergDir_q, emergDir_d;
   logic [1:0]       pend_q, pend_d;
   logic [1:0]       walk_q, walk_d;
   light_e           nsLight_q, ewLight_q;
   logic             phaseStart_q;

   logic             phaseChange;
   logic             expired;
   logic [1:0]       pedReq;
   logic [CNT_W-1:0] cntLoadValue;
   logic [CNT_W-1:0] cntValue;
   logic             cntZero;

   function automatic logic [CNT_W-1:0] loadFor(phase_e ph);
      case (ph)
         NS_GREEN, EW_GREEN:   return CNT_W'(GREEN_TICKS - 1);
         NS_YELLOW, EW_YELLOW: return CNT_W'(YELLOW_TICKS - 1);
         EMERG:                return '0;
         default:              return CNT_W'(ALLRED_TICKS - 1);
      endcase
   endfunction

   phase_timer #(
      .CNT_W       (CNT_W),
      .RESET_VALUE (CNT_W'(ALLRED_TICKS - 1))
   ) uTimer (
      .clk         (clk),
      .reset_i     (rstb),
      .load_i      (phaseChange),
      .loadValue_i (cntLoadValue),
      .tick_i      (tick),
      .count_o     (cntValue),
      .zero_o      (cntZero)
   );

   assign expired = tick & cntZero;
   assign pedReq  = {ped_req_ew, ped_req_ns};

   // Next phase: an active emergency steers every phase boundary toward the
   // all-red that precedes emerg_dir, and cuts a green short without a tick.
   always_comb begin
      phase_d = phase_q;
      case (phase_q)
         AR_NS, AR_EW: begin
            if (expired) begin
               if (emerg_req) begin
                  phase_d = (emerg_dir == dirOf(phase_q)) ? EMERG : allRedOf(emerg_dir);
               end else begin
                  phase_d = greenOf(dirOf(phase_q));
               end
            end
         end
         NS_GREEN, EW_GREEN: begin
            if (emerg_req) begin
               phase_d = (emerg_dir == dirOf(phase_q)) ? EMERG : yellowOf(dirOf(phase_q));
            end else if (expired) begin
               phase_d = yellowOf(dirOf(phase_q));
            end
         end
         NS_YELLOW, EW_YELLOW: begin
            if (expired) begin
               phase_d = emerg_req ? allRedOf(emerg_dir) : allRedOf(~dirOf(phase_q));
            end
         end
         EMERG: begin
            if (!emerg_req) begin
               phase_d = yellowOf(emergDir_q);
            end
         end
         default: phase_d = AR_NS;
      endcase
   end

   assign phaseChange  = (phase_d != phase_q);
   assign cntLoadValue = loadFor(phase_d);
   assign emergDir_d   = (phaseChange && (phase_d == EMERG)) ? emerg_dir : emergDir_q;

   // A request coinciding with green entry is served on that entry; any later
   // request during the green waits for the next green of its direction.
   always_comb begin
      pend_d = pend_q;
      walk_d = walk_q;
      for (int d = 0; d < 2; d++) begin
         if (phase_d != greenOf(d[0])) begin
            walk_d[d] = 1'b0;
            pend_d[d] = pend_q[d] | pedReq[d];
         end else if (phaseChange) begin
            walk_d[d] = WALK_EN & (pend_q[d] | pedReq[d]);
            pend_d[d] = 1'b0;
         end else begin
            pend_d[d] = pend_q[d] | pedReq[d];
            if (tick && (cntValue == WALK_END)) begin
               walk_d[d] = 1'b0;
            end
         end
      end
   end

   // Lamps are decoded from the next state so they change on the same edge
   // as the phase register and never pass through an intermediate value.
   always_ff @(posedge clk) begin
      if (rstb) begin
         phase_q      <= AR_NS;
         emergDir_q   <= DIR_NS;
         pend_q       <= '0;
         walk_q       <= '0;
         nsLight_q    <= RED;
         ewLight_q    <= RED;
         phaseStart_q <= 1'b0;
      end else begin
         phase_q      <= phase_d;
         emergDir_q   <= emergDir_d;
         pend_q       <= pend_d;
         walk_q       <= walk_d;
         nsLight_q    <= lampFor(phase_d, emergDir_d, DIR_NS);
         ewLight_q    <= lampFor(phase_d, emergDir_d, DIR_EW);
         phaseStart_q <= phaseChange;
      end
   end

   assign ns_light    = nsLight_q;
   assign ew_light    = ewLight_q;
   assign walk_ns     = walk_q[0];
   assign walk_ew     = walk_q[1];
   assign phase       = phase_q;
   assign phase_start = phaseStart_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed and randomized checks of traffic_phase_scheduler against a
// tick-counting reference model of the intersection.
module tb_traffic_phase_scheduler;

   localparam int G  = 10;
   localparam int Y  = 3;
   localparam int AR = 2;
   localparam int W  = 6;

   localparam int P_AR_NS = 0;
   localparam int P_NS_G  = 1;
   localparam int P_NS_Y  = 2;
   localparam int P_AR_EW = 3;
   localparam int P_EW_G  = 4;
   localparam int P_EW_Y  = 5;
   localparam int P_EMERG = 6;

   logic       clk = 1'b0;
   logic       rstb, tick, pedNs, pedEw, emergReq, emergDir;
   logic [1:0] nsLight, ewLight;
   logic       walkNs, walkEw, phaseStart;
   logic [2:0] phase;

   int nAsserts = 0;
   int nFail    = 0;

   // Reference model: phase = dir*3 + step (step 0 all-red, 1 green, 2 yellow)
   int mPhase, mElapsed, mEmDir;
   int mWalkLeft[2];
   bit mPend[2];
   bit mStart;

   always #5 clk = ~clk;

   traffic_phase_scheduler #(
      .GREEN_TICKS  (G),
      .YELLOW_TICKS (Y),
      .ALLRED_TICKS (AR),
      .WALK_TICKS   (W),
      .CNT_W        (8)
   ) dut (
      .clk         (clk),
      .rstb        (rstb),
      .tick        (tick),
      .ped_req_ns  (pedNs),
      .ped_req_ew  (pedEw),
      .emerg_req   (emergReq),
      .emerg_dir   (emergDir),
      .ns_light    (nsLight),
      .ew_light    (ewLight),
      .walk_ns     (walkNs),
      .walk_ew     (walkEw),
      .phase       (phase),
      .phase_start (phaseStart)
   );

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic int durOf(int step);
      if (step == 1) return G;
      if (step == 2) return Y;
      return AR;
   endfunction

   function automatic int lampExp(int d);
      if (mPhase == d * 3 + 1) return 1;
      if (mPhase == d * 3 + 2) return 2;
      if ((mPhase == P_EMERG) && (mEmDir == d)) return 1;
      return 0;
   endfunction

   task automatic modelReset();
      mPhase   = P_AR_NS;
      mElapsed = 0;
      mEmDir   = 0;
      mStart   = 1'b0;
      for (int d = 0; d < 2; d++) begin
         mWalkLeft[d] = 0;
         mPend[d]     = 1'b0;
      end
   endtask

   task automatic modelStep(input bit t, input bit pn, input bit pe, input bit er, input bit ed);
      int  nxt;
      int  dir;
      int  step;
      bit  expired;
      bit  req[2];
      nxt    = mPhase;
      dir    = mPhase / 3;
      step   = mPhase % 3;
      req[0] = pn;
      req[1] = pe;
      if (mPhase == P_EMERG) begin
         if (!er) nxt = mEmDir * 3 + 2;
      end else begin
         expired = t && (mElapsed + 1 == durOf(step));
         if (step == 0) begin
            if (expired) nxt = er ? ((int'(ed) == dir) ? P_EMERG : int'(ed) * 3) : dir * 3 + 1;
         end else if (step == 1) begin
            if (er) nxt = (int'(ed) == dir) ? P_EMERG : dir * 3 + 2;
            else if (expired) nxt = dir * 3 + 2;
         end else begin
            if (expired) nxt = er ? int'(ed) * 3 : (1 - dir) * 3;
         end
      end
      mStart = (nxt != mPhase);
      if (mStart) mElapsed = 0;
      else if (t) mElapsed++;
      for (int d = 0; d < 2; d++) begin
         if (nxt == d * 3 + 1) begin
            if (mStart) begin
               mWalkLeft[d] = (mPend[d] || req[d]) ? W : 0;
               mPend[d]     = 1'b0;
            end else begin
               mPend[d] = mPend[d] | req[d];
               if (t && mWalkLeft[d] > 0) mWalkLeft[d]--;
            end
         end else begin
            mWalkLeft[d] = 0;
            mPend[d]     = mPend[d] | req[d];
         end
      end
      if (mStart && nxt == P_EMERG) mEmDir = int'(ed);
      mPhase = nxt;
   endtask

   task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nAsserts++;
      assert (obs === exp) else begin
         nFail++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic checkOutput();
      checkEq("phase", phase, mPhase);
      checkEq("ns_light", nsLight, lampExp(0));
      checkEq("ew_light", ewLight, lampExp(1));
      checkEq("walk_ns", walkNs, mWalkLeft[0] > 0);
      checkEq("walk_ew", walkEw, mWalkLeft[1] > 0);
      checkEq("phase_start", phaseStart, mStart);
      checkEq("interlock", (nsLight != 2'b00) && (ewLight != 2'b00), 0);
   endtask

   task automatic applyStimulus(input bit t, input bit pn, input bit pe, input bit er, input bit ed);
      rstb     = 1'b0;
      tick     = t;
      pedNs    = pn;
      pedEw    = pe;
      emergReq = er;
      emergDir = ed;
      @(posedge clk);
      modelStep(t, pn, pe, er, ed);
      #1;
      checkOutput();
   endtask

   task automatic applyReset(input int cycles);
      rstb = 1'b1;
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk);
         modelReset();
         #1;
         checkOutput();
      end
   endtask

   initial begin
      int  greenCycles, yellowCycles, redCycles, walkCycles;
      bit  er, ed;
      rstb     = 1'b1;
      tick     = 1'b0;
      pedNs    = 1'b0;
      pedEw    = 1'b0;
      emergReq = 1'b0;
      emergDir = 1'b0;
      modelReset();
      applyReset(2);

      $display("[TB] free-running cycle, tick every clock");
      applyStimulus(1, 0, 0, 0, 0);
      checkEq("ar_ns_after_1_tick", phase, P_AR_NS);
      applyStimulus(1, 0, 0, 0, 0);
      checkEq("ns_green_after_2_ticks", phase, P_NS_G);
      greenCycles  = 1;
      yellowCycles = 0;
      redCycles    = 0;
      for (int i = 0; i < 29; i++) begin
         applyStimulus(1, 0, 0, 0, 0);
         if (nsLight == 2'b01) greenCycles++;
         else if (nsLight == 2'b10) yellowCycles++;
         else redCycles++;
      end
      checkEq("ns_green_ticks", greenCycles, 10);
      checkEq("ns_yellow_ticks", yellowCycles, 3);
      checkEq("ns_red_ticks", redCycles, 17);
      applyStimulus(1, 0, 0, 0, 0);
      checkEq("period_phase", phase, P_NS_G);
      checkEq("period_start", phaseStart, 1);

      $display("[TB] pedestrian pulse during EW green");
      for (int i = 0; i < 40 && mPhase != P_EW_G; i++) applyStimulus(1, 0, 0, 0, 0);
      applyStimulus(1, 1, 0, 0, 0);
      walkCycles = 0;
      for (int i = 0; i < 60; i++) begin
         applyStimulus(1, 0, 0, 0, 0);
         if (walkNs) walkCycles++;
      end
      checkEq("walk_ns_cycles", walkCycles, W);

      $display("[TB] emergency toward EW at tick 4 of NS green");
      for (int i = 0; i < 60 && !(mPhase == P_NS_G && mElapsed == 3); i++) applyStimulus(1, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 1, 1);
      checkEq("preempt_ns_yellow", phase, P_NS_Y);
      for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 1, 1);
      checkEq("preempt_ar_ew", phase, P_AR_EW);
      for (int i = 0; i < 2; i++) applyStimulus(1, 0, 0, 1, 1);
      checkEq("preempt_emerg", phase, P_EMERG);
      checkEq("emerg_ew_green", ewLight, 1);
      for (int i = 0; i < 20; i++) applyStimulus(1, 0, 0, 1, 1);
      applyStimulus(1, 0, 0, 0, 0);
      checkEq("release_ew_yellow", phase, P_EW_Y);
      for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 0);
      checkEq("release_ar_ns", phase, P_AR_NS);

      $display("[TB] tick stalled mid NS green");
      for (int i = 0; i < 60 && !(mPhase == P_NS_G && mElapsed == 4); i++) applyStimulus(1, 0, 0, 0, 0);
      for (int i = 0; i < 50; i++) applyStimulus(0, 0, 0, 0, 0);
      checkEq("frozen_phase", phase, P_NS_G);
      for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0, 0, 0);
      checkEq("resume_still_green", phase, P_NS_G);
      applyStimulus(1, 0, 0, 0, 0);
      checkEq("resume_yellow", phase, P_NS_Y);

      $display("[TB] reset while in emergency");
      applyStimulus(1, 1, 1, 1, 0);
      for (int i = 0; i < 40 && mPhase != P_EMERG; i++) applyStimulus(1, 0, 0, 1, 0);
      for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 1, 0);
      applyReset(1);
      checkEq("reset_phase", phase, P_AR_NS);
      checkEq("reset_lamps", {nsLight, ewLight}, 0);
      walkCycles = 0;
      for (int i = 0; i < 40; i++) begin
         applyStimulus(1, 0, 0, 0, 0);
         if (walkNs || walkEw) walkCycles++;
      end
      checkEq("no_walk_after_reset", walkCycles, 0);

      $display("[TB] randomized traffic");
      er = 1'b0;
      ed = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 59) == 0) er = ~er;
         if ($urandom_range(0, 29) == 0) ed = ($urandom_range(0, 1) == 1);
         if ($urandom_range(0, 499) == 0) begin
            applyReset(1);
         end else begin
            applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
                          $urandom_range(0, 19) == 0, er, ed);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
      $finish;
   end

endmodule
